// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: drives the PC register write port, fetches from instruction memory over
// req/ack and hands instructions to decode over valid/ready, tolerating in-flight redirects.
module pc_fetch_ctrl #(
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned INST_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_cur,
  output logic [31:0]       pc_next,
  output logic              pc_ena,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

  state_e              state_q, state_d;
  logic                imem_req_q, imem_req_d;
  logic [31:0]         imem_addr_q, imem_addr_d;
  logic                inst_valid_q, inst_valid_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [31:0]         inst_pc_q, inst_pc_d;

  logic                pc_ena_raw;
  logic [31:0]         pc_next_raw;
  logic [31:0]         redirect_aligned;
  logic [31:0]         step_pc;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign step_pc          = imem_addr_q + 32'(PC_STEP);

  // PC write port: redirect wins over the sequential increment.
  always_comb begin
    pc_ena_raw  = 1'b0;
    pc_next_raw = 32'h0;
    if (redirect) begin
      pc_ena_raw  = 1'b1;
      pc_next_raw = redirect_aligned;
    end else if (state_q == StReq && imem_ack) begin
      pc_ena_raw  = 1'b1;
      pc_next_raw = step_pc;
    end
  end

  // Reset must silence the PC write port without waiting for a clock.
  assign pc_ena  = rst_n & pc_ena_raw;
  assign pc_next = rst_n ? pc_next_raw : 32'h0;

  always_comb begin
    state_d      = state_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    case (state_q)
      StIdle: begin
        // pc_cur is still stale on a redirect edge, so fetch the target directly.
        state_d     = StReq;
        imem_req_d  = 1'b1;
        imem_addr_d = redirect ? redirect_aligned : pc_cur;
      end
      StReq: begin
        if (redirect) begin
          if (imem_ack) begin
            state_d    = StIdle;
            imem_req_d = 1'b0;
          end else begin
            state_d = StDrop;
          end
        end else if (imem_ack) begin
          state_d      = StHold;
          imem_req_d   = 1'b0;
          inst_d       = imem_rdata;
          inst_pc_d    = imem_addr_q;
          inst_valid_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          state_d      = StIdle;
          inst_valid_d = 1'b0;
        end else if (inst_ready) begin
          state_d      = StReq;
          inst_valid_d = 1'b0;
          imem_req_d   = 1'b1;
          imem_addr_d  = pc_cur;
        end
      end
      StDrop: begin
        // Stale response is swallowed; redirects here only move the PC.
        if (imem_ack) begin
          state_d    = StIdle;
          imem_req_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
